fpmult_accum: RTL and testbench
===============================

# fpmult_accum

Fixed-point accumulator directly downstream of the iterative fixed-point multiplier. It consumes the multiplier's product stream over a val/rdy interface and sums a group of terms whose end is marked by `recv_last`. Each finished sum is presented once on a val/rdy output, clamped to n bits, with a saturation flag and a term count. Together with the multiplier it forms a sequential dot-product / MAC path for the filter datapaths.

## Interface

Parameters:
- `n`, default 32: data width of terms and result.
- `d`, default 16: fractional bits. Informational only; fixed-point addition is plain integer addition.
- `sign`, default 1: 1 means terms and result are two's-complement; 0 means unsigned.
- `g`, default 4: guard bits. The internal accumulator is n+g bits.
- `cw`, default 8: width of the term counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `recv_val` in 1: input term valid.
- `recv_rdy` out 1: block can accept a term.
- `recv_msg` in n: term (the multiplier's `c`).
- `recv_last` in 1: this term closes the group. Sampled only on an input transfer.
- `send_val` out 1: result valid.
- `send_rdy` in 1: consumer accepts the result.
- `send_msg` out n: clamped sum.
- `send_sat` out 1: 1 if `send_msg` was clamped.
- `send_count` out cw: number of terms in the group, saturating at 2^cw−1.

## Operation

- Two states: ACC and DONE. Reset enters ACC with `acc`=0 and `count`=0.
- **ACC state**
  - `recv_rdy`=1, `send_val`=0.
  - On an input transfer (`recv_val`&`recv_rdy`):
    - `acc` ← `acc` + ext(`recv_msg`), where ext sign-extends to n+g bits when sign=1 and zero-extends when sign=0.
    - `count` ← min(`count`+1, 2^cw−1).
    - If `recv_last`=1, go to DONE.
- **DONE state**
  - `recv_rdy`=0, `send_val`=1.
  - On `send_rdy`=1: go to ACC and clear `acc` and `count` in the same edge.
  - `send_msg`, `send_sat` and `send_count` are stable for the whole of DONE.
- **Accumulator overflow:** `acc` wraps modulo 2^(n+g). The guard bits make the sum exact for up to 2^g full-scale terms; beyond that the result is undefined by design.
- **Clamp (combinational from `acc`)**
  - sign=1:
    - `acc` > 2^(n−1)−1 → `send_msg`=0x7FF…F, `send_sat`=1.
    - `acc` < −2^(n−1) → `send_msg`=0x800…0, `send_sat`=1.
    - Otherwise `send_msg`=`acc`[n−1:0], `send_sat`=0.
  - sign=0: `acc` ≥ 2^n → `send_msg` is all ones and `send_sat`=1.
- **Outputs in ACC:** `send_msg`, `send_sat` and `send_count` reflect the running values and are don't-care to consumers.
- **Single-term group:** the group may be a single term (`recv_last` set on the first transfer).

## Timing

- Reset values: `recv_rdy`=1, `send_val`=0, `send_msg`=0, `send_sat`=0, `send_count`=0.
- **Latency:** when the last term transfers at edge t, `send_val`=1 in the cycle after t, and `send_msg` already includes that term.
- **Throughput:**
  - One term per cycle in ACC.
  - At least one bubble cycle per group (the DONE state).
  - The next group's first term is accepted in the cycle after the output transfer.
- **Handshake rules**
  - A transfer occurs on a clock edge where val&rdy=1.
  - `recv_rdy` does not depend combinationally on `recv_val`.
  - `send_val` does not depend on `send_rdy`.
- **Backpressure:** with `send_rdy`=0 in DONE, the block holds all send outputs and keeps `recv_rdy`=0 indefinitely.
- **`recv_val`=0 in ACC:** no state change.
- **`reset` at any time (including DONE with `send_val` high):** the next cycle is ACC with `acc` and `count` cleared; the pending result is discarded.
- **Counter:** `count` saturates at 2^cw−1 and does not wrap.

## Test plan

All scenarios use n=32, d=16, g=4, cw=8 unless stated.

1. **Basic sum:** terms 0x00018000 (1.5), then 0x00024000 (2.25) with last → `send_msg`=0x0003C000, `send_sat`=0, `send_count`=2, `send_val` one cycle after the last transfer.
2. **Negative terms:** 0xFFFF0000 three times, last on the third → `send_msg`=0xFFFD0000 (−3.0), `send_sat`=0, `send_count`=3.
3. **Saturation**
   - 0x7FFF0000 + 0x7FFF0000 with last → `send_msg`=0x7FFFFFFF, `send_sat`=1.
   - 0x80000000 + 0x80000000 → `send_msg`=0x80000000, `send_sat`=1.
4. **Backpressure and single term:**
   - Hold `send_rdy`=0 for 5 cycles after a single-term group 0x00010000 with last → `send_val`, `send_msg` and `send_count`=1 stay stable, and `recv_rdy`=0 throughout.
   - Raise `send_rdy` → `recv_rdy`=1 the next cycle, and the next group starts from 0.
5. **Unsigned mode:** sign=0, terms 0xFFFFFFFF + 0x00000001 with last → `send_msg`=0xFFFFFFFF, `send_sat`=1. Separately, 0x10 + 0x20 → 0x30, `send_sat`=0.
6. **Reset mid-group:** accept 0x00050000, assert `reset` for one cycle, then send 0x00010000 with last → `send_msg`=0x00010000, `send_count`=1.

Source files
------------

// File: rtl/fpmult_accum_if.sv
// Product-stream input and result output of the fixed-point accumulator.
// The accumulator sits on the slave side; the producer/consumer pair is the master.
interface fpmult_accum_if #(
    parameter int n  = 32,
    parameter int cw = 8
);
    logic          recv_val;
    logic          recv_rdy;
    logic [n-1:0]  recv_msg;
    logic          recv_last;
    logic          send_val;
    logic          send_rdy;
    logic [n-1:0]  send_msg;
    logic          send_sat;
    logic [cw-1:0] send_count;

    modport master (
        output recv_val, recv_msg, recv_last, send_rdy,
        input  recv_rdy, send_val, send_msg, send_sat, send_count
    );

    modport slave (
        input  recv_val, recv_msg, recv_last, send_rdy,
        output recv_rdy, send_val, send_msg, send_sat, send_count
    );
endinterface

// File: rtl/fpmult_accum.sv
// Sums a recv_last-terminated group of fixed-point terms in an n+g bit accumulator
// and presents the n-bit clamped result, saturation flag and term count once.
module fpmult_accum #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int sign = 1,
    parameter int g    = 4,
    parameter int cw   = 8
) (
    input  logic          clk,
    input  logic          reset,
    fpmult_accum_if.slave bus
);
    localparam int W = n + g;

    typedef enum logic {ACC, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [cw-1:0] count_q, count_d;
    logic [g-1:0]  guard_ext;
    logic [W-1:0]  term_ext;
    logic [n-1:0]  clamp_msg;
    logic          clamp_sat;
    logic          accept;
    logic          result_valid;

    // The fractional point only matters to the consumer; addition is plain integer.
    if (d > n) begin : g_bad_frac
        $error("fpmult_accum: d must not exceed n");
    end

    genvar gi;
    for (gi = 0; gi < g; gi++) begin : g_guard
        assign guard_ext[gi] = (sign != 0) ? bus.recv_msg[n-1] : 1'b0;
    end
    assign term_ext = {guard_ext, bus.recv_msg};

    if (sign != 0) begin : g_clamp_signed
        logic [g:0] top_bits;
        assign top_bits = acc_q[W-1:n-1];
        // In range exactly when the guard bits all replicate the n-bit sign bit.
        always_comb begin
            clamp_msg = acc_q[n-1:0];
            clamp_sat = 1'b0;
            if (!((&top_bits) || !(|top_bits))) begin
                clamp_sat = 1'b1;
                clamp_msg = acc_q[W-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
            end
        end
    end else begin : g_clamp_unsigned
        always_comb begin
            clamp_msg = acc_q[n-1:0];
            clamp_sat = 1'b0;
            if (|acc_q[W-1:n]) begin
                clamp_sat = 1'b1;
                clamp_msg = '1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        accept       = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            ACC: begin
                accept = 1'b1;
                if (bus.recv_val) begin
                    acc_d   = acc_q + term_ext;
                    count_d = (count_q == '1) ? count_q : count_q + cw'(1);
                    if (bus.recv_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (bus.send_rdy) begin
                    state_d = ACC;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACC;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign bus.recv_rdy   = accept;
    assign bus.send_val   = result_valid;
    assign bus.send_msg   = clamp_msg;
    assign bus.send_sat   = clamp_sat;
    assign bus.send_count = count_q;
endmodule

// File: tb/tb_fpmult_accum.sv
// Drives a signed and an unsigned accumulator with directed and random groups and
// checks every cycle against a group-sum model with explicit clamping.
module tb_fpmult_accum;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpmult_accum_if #(.n(32), .cw(8)) b0 ();
    fpmult_accum_if #(.n(32), .cw(8)) b1 ();

    fpmult_accum #(.n(32), .d(16), .sign(1), .g(4), .cw(8)) u_signed (
        .clk(clk), .reset(rst), .bus(b0.slave));
    fpmult_accum #(.n(32), .d(16), .sign(0), .g(4), .cw(8)) u_unsigned (
        .clk(clk), .reset(rst), .bus(b1.slave));

    logic [1:0]  rv, rl, sr;
    logic [31:0] rm [2];
    logic [1:0]  sv_w, rr_w, ss_w;
    logic [31:0] sm_w [2];
    logic [7:0]  sc_w [2];

    assign b0.recv_val = rv[0];  assign b1.recv_val = rv[1];
    assign b0.recv_last = rl[0]; assign b1.recv_last = rl[1];
    assign b0.recv_msg = rm[0];  assign b1.recv_msg = rm[1];
    assign b0.send_rdy = sr[0];  assign b1.send_rdy = sr[1];
    assign sv_w = {b1.send_val, b0.send_val};
    assign rr_w = {b1.recv_rdy, b0.recv_rdy};
    assign ss_w = {b1.send_sat, b0.send_sat};
    assign sm_w[0] = b0.send_msg; assign sm_w[1] = b1.send_msg;
    assign sc_w[0] = b0.send_count; assign sc_w[1] = b1.send_count;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void cmp(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: exact integer sum of the group, clamped to the n-bit range on completion.
    longint      acc_m  [2];
    int          cnt_m  [2];
    bit          pend_v [2];
    logic [31:0] pend_m [2];
    bit          pend_s [2];
    int          pend_c [2];
    bit          armed  [2];

    function automatic void chk(int i, bit sgn);
        longint a;
        if (armed[i]) begin
            cmp($sformatf("send_val[%0d]", i), sv_w[i], pend_v[i]);
            cmp($sformatf("recv_rdy[%0d]", i), rr_w[i], !pend_v[i]);
            if (pend_v[i]) begin
                cmp($sformatf("send_msg[%0d]", i), sm_w[i], pend_m[i]);
                cmp($sformatf("send_sat[%0d]", i), ss_w[i], pend_s[i]);
                cmp($sformatf("send_count[%0d]", i), sc_w[i], pend_c[i]);
            end
        end
        if (rst) begin
            acc_m[i] = 0; cnt_m[i] = 0; pend_v[i] = 0; armed[i] = 1;
        end else if (armed[i]) begin
            if (pend_v[i]) begin
                if (sr[i]) pend_v[i] = 0;
            end else if (rv[i]) begin
                acc_m[i] += sgn ? longint'($signed(rm[i])) : longint'(rm[i]);
                cnt_m[i]++;
                if (rl[i]) begin
                    a = acc_m[i];
                    pend_s[i] = 1;
                    if (sgn && a > 64'sd2147483647)         pend_m[i] = 32'h7FFF_FFFF;
                    else if (sgn && a < -64'sd2147483648)   pend_m[i] = 32'h8000_0000;
                    else if (!sgn && a >= 64'sd4294967296)  pend_m[i] = 32'hFFFF_FFFF;
                    else begin pend_m[i] = a[31:0]; pend_s[i] = 0; end
                    pend_c[i] = (cnt_m[i] > 255) ? 255 : cnt_m[i];
                    pend_v[i] = 1;
                    acc_m[i] = 0; cnt_m[i] = 0;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        chk(0, 1'b1);
        chk(1, 1'b0);
    end

    task automatic put_term(int idx, logic [31:0] m, bit last);
        int t = 0;
        rv[idx] = 1'b1; rm[idx] = m; rl[idx] = last;
        while (!rr_w[idx]) begin
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                cmp("recv_rdy_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        rv[idx] = 1'b0; rl[idx] = 1'b0;
    endtask

    task automatic wait_result(int idx, int hold, bit lit,
                               logic [31:0] em, bit es, int ec);
        cmp("latency_send_val", sv_w[idx], 1);
        if (lit) begin
            cmp("lit_msg", sm_w[idx], em);
            cmp("lit_sat", ss_w[idx], es);
            cmp("lit_count", sc_w[idx], ec);
        end
        $display("result dut%0d: msg=%h sat=%0d count=%0d", idx, sm_w[idx], ss_w[idx], sc_w[idx]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (lit) cmp("hold_msg", sm_w[idx], em);
            cmp("hold_recv_rdy", rr_w[idx], 0);
        end
        sr[idx] = 1'b1;
        @(posedge clk); #1;
        sr[idx] = 1'b0;
        cmp("recv_rdy_after_send", rr_w[idx], 1);
    endtask

    function automatic logic [31:0] rand_term();
        logic [31:0] ext [4];
        ext[0] = 32'h7FFF_FFFF; ext[1] = 32'h8000_0000; ext[2] = 32'h0; ext[3] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 255));
            2:       return 32'(-int'($urandom_range(0, 100000)));
            default: return ext[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        rst = 1'b1; rv = '0; rl = '0; sr = '0; rm[0] = '0; rm[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp("reset_recv_rdy", rr_w[0], 1);
        cmp("reset_send_val", sv_w[0], 0);
        cmp("reset_send_msg", sm_w[0], 0);
        cmp("reset_send_sat", ss_w[0], 0);
        cmp("reset_send_count", sc_w[0], 0);

        put_term(0, 32'h0001_8000, 0); put_term(0, 32'h0002_4000, 1);
        wait_result(0, 0, 1, 32'h0003_C000, 0, 2);

        put_term(0, 32'hFFFF_0000, 0); put_term(0, 32'hFFFF_0000, 0); put_term(0, 32'hFFFF_0000, 1);
        wait_result(0, 1, 1, 32'hFFFD_0000, 0, 3);

        put_term(0, 32'h7FFF_0000, 0); put_term(0, 32'h7FFF_0000, 1);
        wait_result(0, 0, 1, 32'h7FFF_FFFF, 1, 2);
        put_term(0, 32'h8000_0000, 0); put_term(0, 32'h8000_0000, 1);
        wait_result(0, 0, 1, 32'h8000_0000, 1, 2);

        put_term(0, 32'h0001_0000, 1);
        wait_result(0, 5, 1, 32'h0001_0000, 0, 1);
        put_term(0, 32'h0000_0007, 1);
        wait_result(0, 0, 1, 32'h0000_0007, 0, 1);

        put_term(1, 32'hFFFF_FFFF, 0); put_term(1, 32'h0000_0001, 1);
        wait_result(1, 0, 1, 32'hFFFF_FFFF, 1, 2);
        put_term(1, 32'h10, 0); put_term(1, 32'h20, 1);
        wait_result(1, 0, 1, 32'h30, 0, 2);

        put_term(0, 32'h0005_0000, 0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        put_term(0, 32'h0001_0000, 1);
        wait_result(0, 0, 1, 32'h0001_0000, 0, 1);

        for (int k = 0; k < 300; k++) put_term(0, 32'h1, k == 299);
        wait_result(0, 0, 1, 32'h12C, 0, 255);

        for (int k = 0; k < 40; k++) begin
            int idx = k % 2;
            int len = $urandom_range(1, 16);
            for (int j = 0; j < len; j++) begin
                put_term(idx, rand_term(), j == len - 1);
                if (j != len - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            wait_result(idx, $urandom_range(0, 3), 0, 32'h0, 0, 0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
